// File: rtl/npc_mem_pkg.sv
// -----------------------------------------------------------------------------
// npc_mem_pkg
// Shared types and default widths for the NPC memory arbiter slice.
//   arb_state_e : arbiter FSM states (IDLE, REQ, RESP)
//   owner_e     : which requester owns the outstanding transaction
//   NPC_ADDR_W / NPC_DATA_W : default address / data widths
// -----------------------------------------------------------------------------
package npc_mem_pkg;

    localparam int NPC_ADDR_W = 32;
    localparam int NPC_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/npc_rr_arb2.sv
// -----------------------------------------------------------------------------
// npc_rr_arb2
// Two-way round-robin picker, purely combinational. The priority pointer is
// held by the parent.
//   req[1:0] in  : request vector (bit 0 = IFU, bit 1 = LSU)
//   rr       in  : 0 favours bit 0, 1 favours bit 1 when both request
//   gnt[1:0] out : one-hot grant (all zero when nothing requests)
// -----------------------------------------------------------------------------
module npc_rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = rr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/npc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// npc_mem_arbiter
// Shares one non-pipelined memory port between the instruction fetch unit
// (read-only) and the load/store unit (read/write). One transaction is
// outstanding at a time; requesters are picked round-robin and the response
// is steered back to the owner as a one-cycle pulse.
//
// Ports
//   clk, reset                 : single clock, synchronous active-high reset
//   ifu_req_* / ifu_rsp_*      : IFU request (valid/ready/addr) and response
//   lsu_req_* / lsu_rsp_*      : LSU request (valid/ready/wen/addr/wdata/wmask)
//                                and response
//   mem_req_* / mem_rsp_*      : downstream request handshake and response
//                                (response has no back-pressure)
//   arb_busy                   : a transaction is in flight
//
// Configuration
//   ARB_TIMEOUT_EN : when defined, a transaction that stays in REQ/RESP for
//                    TIMEOUT cycles is abandoned and the owner receives an
//                    error response with zero data.
// -----------------------------------------------------------------------------
module npc_mem_arbiter
    import npc_mem_pkg::*;
#(
    parameter int ADDR_W  = NPC_ADDR_W,
    parameter int DATA_W  = NPC_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_req_addr,
    output logic                  ifu_rsp_valid,
    output logic [DATA_W-1:0]     ifu_rsp_data,
    output logic                  ifu_rsp_err,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_req_wen,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    input  logic [DATA_W/8-1:0]   lsu_req_wmask,
    output logic                  lsu_rsp_valid,
    output logic [DATA_W-1:0]     lsu_rsp_data,
    output logic                  lsu_rsp_err,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_wen,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_data,
    input  logic                  mem_rsp_err,

    output logic                  arb_busy
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              rr_q, rr_d;          // requester favoured on a tie
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                ifu_rsp_vld_q, ifu_rsp_vld_d;
    logic                lsu_rsp_vld_q, lsu_rsp_vld_d;

    logic [1:0]          gnt;
    logic                idle;
    logic                accept;
    logic                timeout_hit;

    assign idle = (state_q == IDLE);

    npc_rr_arb2 u_rr_arb2 (
        .req ({lsu_req_valid, ifu_req_valid}),
        .rr  (rr_q == OWN_LSU),
        .gnt (gnt)
    );

    // Ready is only offered while idle, so the winner is accepted in the
    // same cycle it is granted.
    assign ifu_req_ready = idle && gnt[0];
    assign lsu_req_ready = idle && gnt[1];
    assign accept        = ifu_req_ready || lsu_req_ready;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts busy cycles since accept; the cycle in which the count would
    // reach TIMEOUT ends the transaction.
    always_comb begin
        cnt_d       = cnt_q;
        timeout_hit = 1'b0;
        if (accept) begin
            cnt_d = '0;
        end else if (!idle) begin
            cnt_d       = cnt_q + CNT_W'(1);
            timeout_hit = (cnt_d == CNT_W'(TIMEOUT));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT > 1);
`endif

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_d          = rr_q;
        wen_d         = wen_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        ifu_rsp_vld_d = 1'b0;
        lsu_rsp_vld_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = REQ;
                    if (ifu_req_ready) begin
                        owner_d = OWN_IFU;
                        rr_d    = OWN_LSU;
                        wen_d   = 1'b0;
                        addr_d  = ifu_req_addr;
                        wdata_d = '0;
                        wmask_d = '0;
                    end else begin
                        owner_d = OWN_LSU;
                        rr_d    = OWN_IFU;
                        wen_d   = lsu_req_wen;
                        addr_d  = lsu_req_addr;
                        wdata_d = lsu_req_wdata;
                        wmask_d = lsu_req_wmask;
                    end
                end
            end

            // A response arriving here is a protocol violation and is ignored.
            // A handshake in the timeout cycle still wins.
            REQ: begin
                if (mem_req_ready) begin
                    state_d = RESP;
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    rsp_data_d    = '0;
                    rsp_err_d     = 1'b1;
                    ifu_rsp_vld_d = (owner_q == OWN_IFU);
                    lsu_rsp_vld_d = (owner_q == OWN_LSU);
                end
            end

            RESP: begin
                if (mem_rsp_valid) begin
                    state_d       = IDLE;
                    rsp_data_d    = wen_q ? '0 : mem_rsp_data;
                    rsp_err_d     = mem_rsp_err;
                    ifu_rsp_vld_d = (owner_q == OWN_IFU);
                    lsu_rsp_vld_d = (owner_q == OWN_LSU);
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    rsp_data_d    = '0;
                    rsp_err_d     = 1'b1;
                    ifu_rsp_vld_d = (owner_q == OWN_IFU);
                    lsu_rsp_vld_d = (owner_q == OWN_LSU);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset also clears the registered request/response payload so every
    // output starts at zero and an interrupted transaction leaves no trace.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= OWN_IFU;
            rr_q          <= OWN_IFU;
            wen_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wmask_q       <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            ifu_rsp_vld_q <= 1'b0;
            lsu_rsp_vld_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_q          <= rr_d;
            wen_q         <= wen_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wmask_q       <= wmask_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            ifu_rsp_vld_q <= ifu_rsp_vld_d;
            lsu_rsp_vld_q <= lsu_rsp_vld_d;
        end
    end

    assign mem_req_valid = (state_q == REQ);
    assign mem_req_wen   = wen_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;

    // Response data is shared; the error flag is only shown with the pulse.
    assign ifu_rsp_valid = ifu_rsp_vld_q;
    assign ifu_rsp_data  = rsp_data_q;
    assign ifu_rsp_err   = ifu_rsp_vld_q && rsp_err_q;
    assign lsu_rsp_valid = lsu_rsp_vld_q;
    assign lsu_rsp_data  = rsp_data_q;
    assign lsu_rsp_err   = lsu_rsp_vld_q && rsp_err_q;

    assign arb_busy = !idle;

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_npc_mem_arbiter
// Directed bench for npc_mem_arbiter: a table of single transactions plus
// hand-written sequences for back-to-back, round-robin, reset and timeout.
// -----------------------------------------------------------------------------
module tb_npc_mem_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr = '0;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic        ifu_rsp_err;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic        lsu_req_wen = 1'b0;
    logic [31:0] lsu_req_addr = '0;
    logic [31:0] lsu_req_wdata = '0;
    logic [3:0]  lsu_req_wmask = '0;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_data;
    logic        lsu_rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        mem_rsp_err = 1'b0;
    logic        arb_busy;

    int n_tests = 0;
    int n_fail  = 0;

    npc_mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .ifu_rsp_err   (ifu_rsp_err),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_wen   (lsu_req_wen),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_req_wmask (lsu_req_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_data  (lsu_rsp_data),
        .lsu_rsp_err   (lsu_rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_wen   (mem_req_wen),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err),
        .arb_busy      (arb_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_lsu;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] mem_data;
        logic        mem_err;
        int          ready_dly;
        int          rsp_dly;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ifu_ready"},  {31'd0, ifu_req_ready}, 32'd0);
        check({tag, "_lsu_ready"},  {31'd0, lsu_req_ready}, 32'd0);
        check({tag, "_ifu_rspv"},   {31'd0, ifu_rsp_valid}, 32'd0);
        check({tag, "_ifu_data"},   ifu_rsp_data, 32'd0);
        check({tag, "_ifu_err"},    {31'd0, ifu_rsp_err}, 32'd0);
        check({tag, "_lsu_rspv"},   {31'd0, lsu_rsp_valid}, 32'd0);
        check({tag, "_lsu_data"},   lsu_rsp_data, 32'd0);
        check({tag, "_lsu_err"},    {31'd0, lsu_rsp_err}, 32'd0);
        check({tag, "_mem_valid"},  {31'd0, mem_req_valid}, 32'd0);
        check({tag, "_mem_wen"},    {31'd0, mem_req_wen}, 32'd0);
        check({tag, "_mem_addr"},   mem_req_addr, 32'd0);
        check({tag, "_mem_wdata"},  mem_req_wdata, 32'd0);
        check({tag, "_mem_wmask"},  {28'd0, mem_req_wmask}, 32'd0);
        check({tag, "_busy"},       {31'd0, arb_busy}, 32'd0);
    endtask

    task automatic check_mem_req(input string tag, input vec_t v);
        check({tag, "_mvalid"}, {31'd0, mem_req_valid}, 32'd1);
        check({tag, "_maddr"},  mem_req_addr, v.addr);
        check({tag, "_mwen"},   {31'd0, mem_req_wen}, {31'd0, v.is_lsu & v.wen});
        check({tag, "_mwmask"}, {28'd0, mem_req_wmask}, v.is_lsu ? {28'd0, v.wmask} : 32'd0);
        if (v.is_lsu) check({tag, "_mwdata"}, mem_req_wdata, v.wdata);
    endtask

    // One complete transaction from a lone requester.
    task automatic run_txn(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        if (v.is_lsu) begin
            lsu_req_valid = 1'b1;
            lsu_req_wen   = v.wen;
            lsu_req_addr  = v.addr;
            lsu_req_wdata = v.wdata;
            lsu_req_wmask = v.wmask;
        end else begin
            ifu_req_valid = 1'b1;
            ifu_req_addr  = v.addr;
        end
        @(negedge clk);
        check({tag, "_ifu_ready"}, {31'd0, ifu_req_ready}, {31'd0, !v.is_lsu});
        check({tag, "_lsu_ready"}, {31'd0, lsu_req_ready}, {31'd0, v.is_lsu});
        step();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        for (int i = 0; i < v.ready_dly; i++) begin
            @(negedge clk);
            check_mem_req($sformatf("%s_hold%0d", tag, i), v);
            step();
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        check_mem_req({tag, "_hs"}, v);
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < v.rsp_dly; i++) begin
            @(negedge clk);
            check($sformatf("%s_wait%0d_busy", tag, i), {31'd0, arb_busy}, 32'd1);
            check($sformatf("%s_wait%0d_mvalid", tag, i), {31'd0, mem_req_valid}, 32'd0);
            step();
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = v.mem_data;
        mem_rsp_err   = v.mem_err;
        @(negedge clk);
        check({tag, "_resp_mvalid"}, {31'd0, mem_req_valid}, 32'd0);
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_err   = 1'b0;
        @(negedge clk);
        check({tag, "_ifu_rspv"}, {31'd0, ifu_rsp_valid}, {31'd0, !v.is_lsu});
        check({tag, "_lsu_rspv"}, {31'd0, lsu_rsp_valid}, {31'd0, v.is_lsu});
        check({tag, "_data"}, v.is_lsu ? lsu_rsp_data : ifu_rsp_data, v.exp_data);
        check({tag, "_err"}, {31'd0, v.is_lsu ? lsu_rsp_err : ifu_rsp_err}, {31'd0, v.exp_err});
        check({tag, "_busy"}, {31'd0, arb_busy}, 32'd0);
        step();
        @(negedge clk);
        check({tag, "_pulse_end"}, {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            lsu   wen   addr          wdata         wmask    mem_data      err   rdy rsp exp_data      exp_err
        vecs[0] = '{1'b1, 1'b0, 32'h80000100, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0, 0,  0,  32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h80000200, 32'h12345678, 4'b0011, 32'hFFFFFFFF, 1'b0, 5,  0,  32'h00000000, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'h80000000, 32'h0,        4'b0000, 32'h00000413, 1'b1, 0,  0,  32'h00000413, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 32'h80000004, 32'h0,        4'b0000, 32'hCAFEF00D, 1'b0, 2,  3,  32'hCAFEF00D, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h80000010, 32'hA5A5A5A5, 4'b1111, 32'h55AA55AA, 1'b1, 1,  1,  32'h55AA55AA, 1'b1};

        // Reset state
        do_reset();
        @(negedge clk);
        check_quiet("rst");
        step();

        // Single transactions
        for (int i = 0; i < 5; i++) begin
            run_txn(i, vecs[i]);
        end

        // Errored IFU fetch, LSU accepted in the response-pulse cycle
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h80000008;
        @(negedge clk);
        check("b2b_ifu_ready", {31'd0, ifu_req_ready}, 32'd1);
        step();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0;
        mem_rsp_err   = 1'b1;
        lsu_req_valid = 1'b1;
        lsu_req_wen   = 1'b0;
        lsu_req_addr  = 32'h80000300;
        @(negedge clk);
        check("b2b_lsu_ready_busy", {31'd0, lsu_req_ready}, 32'd0);
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        @(negedge clk);
        check("b2b_ifu_rspv", {31'd0, ifu_rsp_valid}, 32'd1);
        check("b2b_ifu_err",  {31'd0, ifu_rsp_err}, 32'd1);
        check("b2b_lsu_ready", {31'd0, lsu_req_ready}, 32'd1);
        step();
        lsu_req_valid = 1'b0;
        @(negedge clk);
        check("b2b_mvalid", {31'd0, mem_req_valid}, 32'd1);
        check("b2b_maddr", mem_req_addr, 32'h80000300);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h00001111;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        @(negedge clk);
        check("b2b_lsu_rspv", {31'd0, lsu_rsp_valid}, 32'd1);
        check("b2b_lsu_data", lsu_rsp_data, 32'h00001111);
        check("b2b_ifu_quiet", {31'd0, ifu_rsp_valid}, 32'd0);
        step();

        // Round robin with both requesters always valid
        do_reset();
        ifu_req_addr  = 32'h00001000;
        lsu_req_addr  = 32'h00002000;
        lsu_req_wen   = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        mem_req_ready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            if (g > 0) begin
                check($sformatf("rr%0d_prev_ifu_rspv", g), {31'd0, ifu_rsp_valid}, {31'd0, ((g - 1) % 2) == 0});
                check($sformatf("rr%0d_prev_lsu_rspv", g), {31'd0, lsu_rsp_valid}, {31'd0, ((g - 1) % 2) == 1});
            end
            check($sformatf("rr%0d_ifu_ready", g), {31'd0, ifu_req_ready}, {31'd0, (g % 2) == 0});
            check($sformatf("rr%0d_lsu_ready", g), {31'd0, lsu_req_ready}, {31'd0, (g % 2) == 1});
            step();
            @(negedge clk);
            check($sformatf("rr%0d_maddr", g), mem_req_addr, (g % 2) == 0 ? 32'h00001000 : 32'h00002000);
            step();
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'h0;
            step();
            mem_rsp_valid = 1'b0;
            if (g == 3) begin
                ifu_req_valid = 1'b0;
                lsu_req_valid = 1'b0;
                mem_req_ready = 1'b0;
            end
        end
        @(negedge clk);
        check("rr_last_lsu_rspv", {31'd0, lsu_rsp_valid}, 32'd1);
        check("rr_last_ifu_rspv", {31'd0, ifu_rsp_valid}, 32'd0);
        step();

        // Reset while waiting for the memory response
        do_reset();
        lsu_req_valid = 1'b1;
        lsu_req_wen   = 1'b0;
        lsu_req_addr  = 32'h80000400;
        step();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        @(negedge clk);
        check("mid_rst_busy_resp", {31'd0, arb_busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h00000099;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_quiet($sformatf("mid_rst%0d", i));
            step();
        end

        // Memory that never answers
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h80000800;
        @(negedge clk);
        check("to_accept", {31'd0, ifu_req_ready}, 32'd1);
        step();
        ifu_req_valid = 1'b0;
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("to_wait%0d_rspv", k), {31'd0, ifu_rsp_valid}, 32'd0);
            check($sformatf("to_wait%0d_busy", k), {31'd0, arb_busy}, 32'd1);
            step();
        end
        @(negedge clk);
        check("to_rspv",   {31'd0, ifu_rsp_valid}, 32'd1);
        check("to_err",    {31'd0, ifu_rsp_err}, 32'd1);
        check("to_data",   ifu_rsp_data, 32'd0);
        check("to_lsu",    {31'd0, lsu_rsp_valid}, 32'd0);
        check("to_mvalid", {31'd0, mem_req_valid}, 32'd0);
        check("to_busy",   {31'd0, arb_busy}, 32'd0);
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h77777777;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        @(negedge clk);
        check("to_late_ifu", {31'd0, ifu_rsp_valid}, 32'd0);
        check("to_late_lsu", {31'd0, lsu_rsp_valid}, 32'd0);
        check("to_late_busy", {31'd0, arb_busy}, 32'd0);
        step();
`else
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("hang%0d_rspv", k), {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
            check($sformatf("hang%0d_busy", k), {31'd0, arb_busy}, 32'd1);
            step();
        end
        do_reset();
        @(negedge clk);
        check_quiet("hang_rst");
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
